// File: rtl/vgafb_pkg.sv
// vgafb_pkg: shared FSM state type, default framebuffer geometry and the
// bank-rotation helper used by the multi-buffered VGA framebuffer.
package vgafb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 16;
  localparam int DEF_DEPTH = 38400;   // 640x480 mono, 8 pixels per word

  // Bank indices are 2 bits wide, which covers the 2..4 bank range.
  function automatic logic [1:0] next_idx(input logic [1:0] idx, input int nbuf);
    if (int'(idx) >= nbuf - 1) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/vgafb_bank.sv
// vgafb_bank: one simple dual-port frame bank, DW x DEPTH, with a synchronous
// write port and a registered read port whose output register is reset.
module vgafb_bank #(
  parameter int DW    = 8,
  parameter int IW    = 16,
  parameter int DEPTH = 38400
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; a reset port on it would stop it
  // mapping onto block RAM. Only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vgafb_multibuf.sv
// vgafb_multibuf: NBUF-bank VGA framebuffer with CPU write port, fill engine
// and tear-free swap at frame start. Define VGAFB_DROP_CNT_EN for drop_cnt.
module vgafb_multibuf
  import vgafb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NBUF  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_we,
  input  logic          fill_rq,
  input  logic [DW-1:0] fill_val,
  output logic          fill_ack,
  input  logic          swap_rq,
  output logic          swap_ack,
  input  logic          frame_start,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic [1:0]    front_idx,
  output logic          busy,
  output logic [15:0]   drop_cnt
);

  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] fill_val_q;

  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_we_q;

  logic          swap_pend;
  logic [1:0]    back_idx;
  logic [1:0]    front_q;
  logic          oob_q;

  logic          cpu_ok;
  logic          cpu_we;
  logic          fill_we;
  logic [IW-1:0] bank_wr_addr;
  logic [DW-1:0] bank_wr_data;
  logic [DW-1:0] rd_bank [NBUF];

  assign back_idx     = next_idx(front_idx, NBUF);
  assign cpu_ok       = wr_we_q && ({1'b0, wr_addr_q} < DEPTH_W);
  assign cpu_we       = cpu_ok && (state == ST_IDLE);
  assign fill_we      = (state == ST_FILL);
  assign bank_wr_addr = fill_we ? fill_cnt[IW-1:0] : wr_addr_q[IW-1:0];
  assign bank_wr_data = fill_we ? fill_val_q : wr_data_q;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_we_q   <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
      wr_we_q   <= wr_we;
    end
  end

  // Fill engine. fill_ack high blocks a restart for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      fill_cnt   <= '0;
      fill_val_q <= '0;
      fill_ack   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fill_ack <= 1'b0;
          if (fill_rq && !fill_ack) begin
            state      <= ST_FILL;
            fill_val_q <= fill_val;
            fill_cnt   <= '0;
            busy       <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_cnt == LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            fill_ack <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only a pend registered before this frame_start is serviced, and never
  // while the fill engine owns the back bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_idx <= 2'd0;
      swap_pend <= 1'b0;
      swap_ack  <= 1'b0;
    end else if (frame_start && swap_pend && state == ST_IDLE) begin
      front_idx <= back_idx;
      swap_pend <= 1'b0;
      swap_ack  <= 1'b1;
    end else begin
      swap_ack <= 1'b0;
      if (swap_rq && !swap_ack) swap_pend <= 1'b1;
    end
  end

  // Bank select and range flag travel with the read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q <= 2'd0;
      oob_q   <= 1'b0;
    end else begin
      front_q <= front_idx;
      oob_q   <= ({1'b0, scan_addr} >= DEPTH_W);
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_bank
    vgafb_bank #(
      .DW    (DW),
      .IW    (IW),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      ((cpu_we || fill_we) && (back_idx == 2'(b))),
      .wr_addr (bank_wr_addr),
      .wr_data (bank_wr_data),
      .rd_addr (scan_addr[IW-1:0]),
      .rd_data (rd_bank[b])
    );
  end

  // NOTE: default assignment first so no path through this block leaves
  // scan_data unassigned and infers a latch.
  always_comb begin
    scan_data = '0;
    for (int b = 0; b < NBUF; b++) begin
      if (!oob_q && front_q == 2'(b)) scan_data = rd_bank[b];
    end
  end

`ifdef VGAFB_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (cpu_ok && state == ST_FILL && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_vgafb_multibuf.sv
// tb_vgafb_multibuf: directed bench for vgafb_multibuf, run with a reduced
// DEPTH so full fills fit a short simulation; a second NBUF=3 instance checks rotation.
module tb_vgafb_multibuf;

  localparam int DW        = 8;
  localparam int AW        = 16;
  localparam int TB_DEPTH  = 2000;
  localparam int FRAME_GAP = 420;
`ifdef VGAFB_DROP_CNT_EN
  localparam int EXP_DROP = 10;
`else
  localparam int EXP_DROP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_we = 1'b0;
  logic          fill_rq = 1'b0;
  logic [DW-1:0] fill_val = '0;
  logic          fill_ack;
  logic          swap_rq = 1'b0;
  logic          swap_ack;
  logic          frame_start = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic [DW-1:0] scan_data;
  logic [1:0]    front_idx;
  logic          busy;
  logic [15:0]   drop_cnt;

  logic          swap_rq3 = 1'b0;
  logic          frame_start3 = 1'b0;
  logic          fill_ack3, swap_ack3, busy3;
  logic [DW-1:0] scan_data3;
  logic [1:0]    front3;
  logic [15:0]   drop_cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vgafb_multibuf #(.DW(DW), .AW(AW), .DEPTH(TB_DEPTH), .NBUF(2)) dut (
    .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
    .fill_rq(fill_rq), .fill_val(fill_val), .fill_ack(fill_ack),
    .swap_rq(swap_rq), .swap_ack(swap_ack), .frame_start(frame_start),
    .scan_addr(scan_addr), .scan_data(scan_data), .front_idx(front_idx),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  vgafb_multibuf #(.DW(DW), .AW(AW), .DEPTH(16), .NBUF(3)) dut3 (
    .clk(clk), .rst(rst), .wr_addr(16'd0), .wr_data(8'd0), .wr_we(1'b0),
    .fill_rq(1'b0), .fill_val(8'd0), .fill_ack(fill_ack3),
    .swap_rq(swap_rq3), .swap_ack(swap_ack3), .frame_start(frame_start3),
    .scan_addr(16'd0), .scan_data(scan_data3), .front_idx(front3),
    .busy(busy3), .drop_cnt(drop_cnt3)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy, n_ack, n_swap, n_mis;
    logic [1:0] exp_front3 [3];

    // Writes go to the back bank (1); 2053 aliases 5 in the low 11 bits and
    // 2000 is just past the end, so both must be ignored.
    vecs[0] = '{16'd5,    8'hA5, 8'hA5};
    vecs[1] = '{16'd1999, 8'h3C, 8'h3C};
    vecs[2] = '{16'd0,    8'h11, 8'h11};
    vecs[3] = '{16'd1000, 8'h7E, 8'h7E};
    vecs[4] = '{16'd2053, 8'hEE, 8'h00};
    vecs[5] = '{16'd2000, 8'h99, 8'h00};
    exp_front3[0] = 2'd1;
    exp_front3[1] = 2'd2;
    exp_front3[2] = 2'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    check("rst_front",    32'(front_idx), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_fill_ack", 32'(fill_ack), 0);
    check("rst_swap_ack", 32'(swap_ack), 0);
    check("rst_scan",     32'(scan_data), 0);
    check("rst_drop",     32'(drop_cnt), 0);

    // CPU writes, swap, readback through the new front bank
    for (int i = 0; i < 6; i++) begin
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      wr_we   = 1'b1;
      step();
    end
    wr_we = 1'b0;
    step();
    step();
    swap_rq = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    swap_rq = 1'b0;
    check("swap1_ack",   32'(swap_ack), 1);
    check("swap1_front", 32'(front_idx), 1);
    step();
    check("swap1_ack_drop", 32'(swap_ack), 0);
    for (int i = 0; i < 6; i++) begin
      scan_addr = vecs[i].addr;
      step();
      check($sformatf("rd_%0d", vecs[i].addr), 32'(scan_data), 32'(vecs[i].exp));
    end

    // NBUF=3 rotation
    for (int k = 0; k < 3; k++) begin
      swap_rq3 = 1'b1;
      step();
      frame_start3 = 1'b1;
      step();
      frame_start3 = 1'b0;
      swap_rq3 = 1'b0;
      check($sformatf("nbuf3_ack_%0d", k), 32'(swap_ack3), 1);
      check($sformatf("nbuf3_front_%0d", k), 32'(front3), 32'(exp_front3[k]));
      step();
      check($sformatf("nbuf3_ack_low_%0d", k), 32'(swap_ack3), 0);
    end

    // Fill bank 0 with 55, with dropped CPU writes and a deferred swap
    fill_val = 8'h55;
    fill_rq  = 1'b1;
    step();
    fill_rq = 1'b0;
    n_busy = 0; n_ack = 0; n_swap = 0;
    for (int i = 0; i < TB_DEPTH + 20; i++) begin
      if (busy) n_busy++;
      if (fill_ack) n_ack++;
      if (swap_ack) n_swap++;
      wr_we       = (i >= 100 && i < 110);
      wr_addr     = 16'd7;
      wr_data     = 8'hAA;
      swap_rq     = (i >= 200);
      frame_start = (i == 300);
      step();
    end
    wr_we = 1'b0;
    check("fill_busy_cycles", 32'(n_busy), TB_DEPTH);
    check("fill_ack_pulses",  32'(n_ack), 1);
    check("fill_no_swap",     32'(n_swap), 0);
    check("fill_front_held",  32'(front_idx), 1);
    check("drop_cnt",         32'(drop_cnt), EXP_DROP);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    swap_rq = 1'b0;
    check("swap2_ack",   32'(swap_ack), 1);
    check("swap2_front", 32'(front_idx), 0);
    n_mis = 0;
    for (int a = 0; a < TB_DEPTH; a++) begin
      scan_addr = 16'(a);
      step();
      if (scan_data !== 8'h55) n_mis++;
    end
    check("fill_all_55", 32'(n_mis), 0);
    scan_addr = 16'(TB_DEPTH);
    step();
    check("fill_past_end", 32'(scan_data), 0);

    // swap_rq and frame_start together with no earlier pend
    swap_rq = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("same_cycle_no_ack",   32'(swap_ack), 0);
    check("same_cycle_no_front", 32'(front_idx), 0);
    n_swap = 0;
    for (int i = 0; i < FRAME_GAP; i++) begin
      if (swap_ack) n_swap++;
      step();
    end
    check("gap_no_swap", 32'(n_swap), 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    swap_rq = 1'b0;
    check("next_frame_ack",   32'(swap_ack), 1);
    check("next_frame_front", 32'(front_idx), 1);

    // Reset mid-fill at count 1000
    fill_val = 8'h77;
    fill_rq  = 1'b1;
    step();
    fill_rq = 1'b0;
    repeat (1000) step();
    check("midfill_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_busy",     32'(busy), 0);
    check("abort_fill_ack", 32'(fill_ack), 0);
    check("abort_front",    32'(front_idx), 0);
    check("abort_drop",     32'(drop_cnt), 0);
    #2 rst = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (fill_ack) n_ack++;
    end
    check("abort_no_ack", 32'(n_ack), 0);

    // New fill with fill_rq held: completes, then restarts after fill_ack
    fill_val = 8'h3C;
    fill_rq  = 1'b1;
    step();
    n_busy = 0;
    for (int i = 0; i < TB_DEPTH; i++) begin
      if (busy) n_busy++;
      step();
    end
    check("refill_busy_cycles", 32'(n_busy), TB_DEPTH);
    check("refill_busy_low",    32'(busy), 0);
    check("refill_ack",         32'(fill_ack), 1);
    step();
    check("hold_no_retrigger", 32'(busy), 0);
    check("hold_ack_low",      32'(fill_ack), 0);
    step();
    check("hold_retrigger", 32'(busy), 1);
    fill_rq = 1'b0;
    n_ack = 0;
    for (int i = 0; i < TB_DEPTH + 5; i++) begin
      if (fill_ack) n_ack++;
      step();
    end
    check("retrigger_ack", 32'(n_ack), 1);
    swap_rq = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    swap_rq = 1'b0;
    check("swap3_front", 32'(front_idx), 1);
    scan_addr = 16'd1000;
    step();
    check("refill_rd_1000", 32'(scan_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vgafb_multibuf.md
Name: vgafb_multibuf

Overview:
- Parametrised successor to the 640x480 mono double-buffered framebuffer top.
- Holds NBUF frame banks; the CPU writes the back bank while scanout reads the front bank.
- Provides a fill engine with a programmable fill value and a swap request that takes effect only at frame start, so no tearing occurs.
- Sits between the CPU video-memory write port and the VGA timing/pixel generator. That generator supplies scan_addr and frame_start.

Parameters:
- DW, 8, data bits per memory word.
- AW, 16, address width.
- DEPTH, 38400, words per bank; must satisfy DEPTH <= 2**AW.
- NBUF, 2, number of banks (2 = double, 3 = triple buffering); legal range 2..4.

Ports:
- clk  in  1  system clock (100MHz).
- rst  in  1  asynchronous, active-low reset.
- wr_addr  in  AW  CPU write address (back bank).
- wr_data  in  DW  CPU write data.
- wr_we  in  1  CPU write enable.
- fill_rq  in  1  level; request fill of the back bank.
- fill_val  in  DW  fill value, sampled when the fill starts.
- fill_ack  out  1  one-cycle pulse when the fill completes.
- swap_rq  in  1  level; request a bank rotation at the next frame_start.
- swap_ack  out  1  one-cycle pulse when the rotation is performed.
- frame_start  in  1  one-cycle pulse from the timing generator (start of vertical blank).
- scan_addr  in  AW  scanout read address.
- scan_data  out  DW  front-bank data, 1-cycle latency.
- front_idx  out  2  index of the current front bank.
- busy  out  1  high while FILL is active.
- drop_cnt  out  16  dropped-write counter; see Optional Feature.

Behaviour:
- Reset (async, rst=0): FSM=IDLE, front_idx=0, back index=1, fill_ack=0, swap_ack=0, busy=0, scan_data=0, swap_pend=0, fill counter=0, write pipeline register cleared. Bank contents are not reset.
- Back index is always (front_idx+1) mod NBUF.
- CPU write path:
  - wr_addr, wr_data and wr_we are registered one stage; the write lands in the back bank on the following clk.
  - A write with wr_addr >= DEPTH is ignored.
  - A write registered while FSM=FILL is dropped (see Optional Feature).
- FSM states are IDLE and FILL.
  - IDLE -> FILL: when fill_rq=1 and fill_ack=0. Capture fill_val, counter=0, busy=1.
  - FILL: each cycle, write the captured value at the counter address in the back bank, then increment the counter. Exactly addresses 0..DEPTH-1 are written, DEPTH cycles in total.
  - FILL -> IDLE: on the cycle that writes DEPTH-1. fill_ack=1 for the next cycle and busy=0.
  - fill_rq still high while fill_ack=1 does not retrigger. If it is still high the cycle after fill_ack, a new fill starts.
- Swap:
  - swap_rq=1 sets swap_pend (sticky until serviced).
  - Service condition: frame_start=1 and swap_pend=1 already registered, i.e. set in an earlier cycle, and FSM=IDLE.
  - On service: front_idx <= (front_idx+1) mod NBUF, swap_pend cleared, swap_ack=1 for one cycle.
  - swap_rq and frame_start in the same cycle with no prior pend: the rotation waits for the next frame_start.
  - frame_start during FILL: the rotation is deferred to the first frame_start after the fill completes.
  - A swap_rq arriving during swap_ack does not set swap_pend; the requester must drop swap_rq after swap_ack.
- Scanout:
  - scan_data <= bank[front_idx][scan_addr] one cycle after scan_addr.
  - The bank select is registered together with the address, so a rotation never mixes banks within one read.
  - scan_addr >= DEPTH returns 0.
- Reset during FILL: the fill aborts immediately. No fill_ack is issued and bank contents are left partially filled.

Optional Feature:
- Macro VGAFB_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit saturating count of CPU writes (wr_we registered, in-range address) discarded because FSM=FILL. It resets to 0 on rst and sticks at 16'hFFFF.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package vgafb_pkg holds:
  - FSM state constants (ST_IDLE, ST_FILL);
  - default DEPTH/AW/DW;
  - function next_idx(idx, NBUF) for modulo rotation.
- Sub-module vgafb_bank: one simple dual-port bank (sync write port, registered read), DW x DEPTH. It is instantiated NBUF times by generate, and the top muxes the read data by the registered front index.

Test Plan:
- Reset, then write addr 5 = 8'hA5 and addr 38399 = 8'h3C; swap_rq plus one frame_start -> swap_ack pulses, front_idx=1, scan_addr 5 -> 8'hA5 one cycle later, 38399 -> 8'h3C.
- fill_rq with fill_val=8'h55 -> busy for exactly 38400 cycles, fill_ack single pulse. After a swap, every address reads 8'h55 and address 38400 is never written.
- Fill in progress, CPU writes 10 times -> all dropped, drop_cnt=10 (macro on) or 0 (off). A frame_start with swap pending during the fill is ignored; the swap happens on the first frame_start after fill_ack.
- NBUF=3: three swaps -> front_idx sequence 0->1->2->0, each swap_ack aligned to its frame_start.
- swap_rq and frame_start asserted in the same cycle -> no swap; the swap occurs on the next frame_start, 800*525 cycles later at 25MHz pixel timing.
- Assert rst low mid-fill at count 1000 -> busy=0, fill_ack never pulses, front_idx=0; after release a new fill_rq completes normally.
